// File: rtl/dm_console_rx_if.sv
// Byte-stream handshake plus CPU data-memory bus for the console receive peripheral.
// The master side is the byte source and CPU; the slave side is the peripheral.
interface dm_console_rx_if;
    logic [7:0]  in_data_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] dm_addr_i;
    logic [31:0] dm_data_s_i;
    logic [3:0]  dm_data_select_i;
    logic        dm_load_i;
    logic        dm_store_i;
    logic [31:0] dm_data_l_o;
    logic        dm_load_done_o;
    logic        dm_store_done_o;
    logic        irq_o;

    modport master (
        output in_data_i, in_valid_i, dm_addr_i, dm_data_s_i, dm_data_select_i,
               dm_load_i, dm_store_i,
        input  in_ready_o, dm_data_l_o, dm_load_done_o, dm_store_done_o, irq_o
    );

    modport slave (
        input  in_data_i, in_valid_i, dm_addr_i, dm_data_s_i, dm_data_select_i,
               dm_load_i, dm_store_i,
        output in_ready_o, dm_data_l_o, dm_load_done_o, dm_store_done_o, irq_o
    );
endinterface

// File: rtl/dm_console_rx.sv
// Console receive peripheral: buffers an incoming byte stream in a FIFO and
// exposes it to the CPU through DATA/STATUS/CTRL registers on the dm bus.
module dm_console_rx #(
    parameter logic [31:0] BASE_ADDR  = 32'h1000_0010,
    parameter int          DEPTH_LOG2 = 4
) (
    input  logic           wclk,
    input  logic           rst,
    dm_console_rx_if.slave bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef logic [DEPTH_LOG2-1:0] ptr_t;
    typedef logic [DEPTH_LOG2:0]   cnt_t;
    typedef enum logic [1:0] {
        REG_DATA   = 2'd0,
        REG_STATUS = 2'd1,
        REG_CTRL   = 2'd2,
        REG_RSVD   = 2'd3
    } reg_off_t;

    logic [7:0]  mem [DEPTH];
    ptr_t        wr_ptr;
    ptr_t        rd_ptr;
    cnt_t        count;
    logic        ie;
    logic        ovf;
    logic        flush_pending;
    logic        store_ack;
    logic [31:0] load_data;
    logic        load_done;
    logic        store_done;
    logic        irq;

    logic        hit;
    reg_off_t    offset;
    logic        load_hit;
    logic        store_hit;
    logic        ctrl_wr;
    logic        flush;
    logic        ovf_clr;
    logic        empty;
    logic        full;
    logic        ready;
    logic        push;
    logic        pop;
    logic [31:0] rd_value;

    assign hit       = (bus.dm_addr_i[31:4] == BASE_ADDR[31:4]);
    assign offset    = reg_off_t'(bus.dm_addr_i[3:2]);
    assign load_hit  = bus.dm_load_i && hit;
    assign store_hit = bus.dm_store_i && hit;
    assign ctrl_wr   = store_hit && (offset == REG_CTRL) && bus.dm_data_select_i[0];
    assign flush     = ctrl_wr && bus.dm_data_s_i[0];
    assign ovf_clr   = ctrl_wr && bus.dm_data_s_i[2];

    assign empty = (count == '0);
    assign full  = (count == cnt_t'(DEPTH));
    // Source is stalled for one cycle after a flush commits.
    assign ready = !full && !flush_pending;
    assign push  = bus.in_valid_i && ready;
    assign pop   = load_hit && (offset == REG_DATA) && !empty;

    assign bus.in_ready_o      = ready;
    assign bus.dm_data_l_o     = load_data;
    assign bus.dm_load_done_o  = load_done;
    assign bus.dm_store_done_o = store_done;
    assign bus.irq_o           = irq;

    always_comb begin
        // NOTE: default first so every path assigns rd_value and no latch is inferred.
        rd_value = '0;
        case (offset)
            REG_DATA:   if (!empty) rd_value = {1'b1, 23'b0, mem[rd_ptr]};
            REG_STATUS: rd_value = {ovf, 15'b0, 16'(count)};
            REG_CTRL:   rd_value = {30'b0, ie, 1'b0};
            default:    rd_value = '0;
        endcase
    end

    // NOTE: storage has no reset; the pointers and count alone define what is valid.
    always_ff @(posedge wclk) begin
        if (push) mem[wr_ptr] <= bus.in_data_i;
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge wclk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            // Flush wins over a push or pop landing on the same edge.
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + ptr_t'(1);
            if (pop)  rd_ptr <= rd_ptr + ptr_t'(1);
            case ({push, pop})
                2'b10:   count <= count + cnt_t'(1);
                2'b01:   count <= count - cnt_t'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge wclk or negedge rst) begin
        if (!rst) begin
            ie            <= 1'b0;
            ovf           <= 1'b0;
            flush_pending <= 1'b0;
            store_ack     <= 1'b0;
            store_done    <= 1'b0;
            load_data     <= '0;
            load_done     <= 1'b0;
            irq           <= 1'b0;
        end else begin
            if (ctrl_wr) ie <= bus.dm_data_s_i[1];
            // A fresh overflow outranks a clear on the same edge so no event is lost.
            if (bus.in_valid_i && full) ovf <= 1'b1;
            else if (ovf_clr)           ovf <= 1'b0;
            flush_pending <= flush;
            store_ack     <= store_hit;
            store_done    <= store_ack;
            load_done     <= load_hit;
            if (load_hit) load_data <= rd_value;
            irq <= !empty && ie;
        end
    end
endmodule

// File: tb/tb_dm_console_rx.sv
// Self-checking bench for dm_console_rx: directed scenarios plus a randomized
// phase, all compared against a queue-based reference model.
module tb_dm_console_rx;
    localparam int          DEPTH = 16;
    localparam logic [31:0] BASE  = 32'h1000_0010;

    logic wclk = 1'b0;
    logic rst  = 1'b0;

    dm_console_rx_if bus ();

    dm_console_rx #(.BASE_ADDR(BASE), .DEPTH_LOG2(4)) dut (
        .wclk (wclk),
        .rst  (rst),
        .bus  (bus.slave)
    );

    always #5 wclk = ~wclk;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]  q[$];
    bit          m_ie, m_ovf, m_flush_pend, m_store_ack;
    logic [31:0] e_data;
    bit          e_ldone, e_sdone, e_irq;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_ie = 0; m_ovf = 0; m_flush_pend = 0; m_store_ack = 0;
        e_data = '0; e_ldone = 0; e_sdone = 0; e_irq = 0;
    endtask

    task automatic bus_set(input bit ld, input bit st, input logic [31:0] addr,
                           input logic [31:0] sd, input logic [3:0] sel);
        bus.dm_load_i        = ld;
        bus.dm_store_i       = st;
        bus.dm_addr_i        = addr;
        bus.dm_data_s_i      = sd;
        bus.dm_data_select_i = sel;
    endtask

    task automatic src_set(input bit v, input logic [7:0] d);
        bus.in_valid_i = v;
        bus.in_data_i  = d;
    endtask

    // One clock: predict from the inputs now on the bus, advance, compare.
    task automatic tick(input string tag);
        int          sz, off;
        bit          rdy, in_win, ld, st, cw, do_flush, do_push, do_pop;
        logic [31:0] rd;
        sz  = q.size();
        rdy = (sz < DEPTH) && !m_flush_pend;
        check({tag, ":ready"}, 32'(bus.in_ready_o), 32'(rdy));
        in_win   = (bus.dm_addr_i >= BASE) && (bus.dm_addr_i < BASE + 32'd16);
        off      = in_win ? int'((bus.dm_addr_i - BASE) >> 2) : 0;
        ld       = in_win && bus.dm_load_i;
        st       = in_win && bus.dm_store_i;
        cw       = st && (off == 2) && bus.dm_data_select_i[0];
        do_flush = cw && bus.dm_data_s_i[0];
        do_push  = bus.in_valid_i && rdy;
        do_pop   = ld && (off == 0) && (sz > 0);
        case (off)
            0:       rd = (sz > 0) ? {1'b1, 23'b0, q[0]} : 32'h0;
            1:       rd = {m_ovf, 15'b0, 16'(sz)};
            2:       rd = {30'b0, m_ie, 1'b0};
            default: rd = 32'h0;
        endcase
        e_irq = (sz != 0) && m_ie;
        if (bus.in_valid_i && sz == DEPTH) m_ovf = 1;
        else if (cw && bus.dm_data_s_i[2]) m_ovf = 0;
        if (cw) m_ie = bus.dm_data_s_i[1];
        if (do_flush) q.delete();
        else begin
            if (do_pop)  void'(q.pop_front());
            if (do_push) q.push_back(bus.in_data_i);
        end
        e_sdone      = m_store_ack;
        m_store_ack  = st;
        m_flush_pend = do_flush;
        e_ldone      = ld;
        if (ld) e_data = rd;
        @(posedge wclk);
        #1;
        check({tag, ":ldone"}, 32'(bus.dm_load_done_o), 32'(e_ldone));
        check({tag, ":sdone"}, 32'(bus.dm_store_done_o), 32'(e_sdone));
        check({tag, ":irq"},   32'(bus.irq_o), 32'(e_irq));
        check({tag, ":data"},  bus.dm_data_l_o, e_data);
    endtask

    task automatic idle();
        bus_set(0, 0, 32'h0, 32'h0, 4'h0);
    endtask

    task automatic load(input logic [31:0] addr, input string tag);
        bus_set(1, 0, addr, 32'h0, 4'h0);
        tick(tag);
        idle();
    endtask

    task automatic store_ctrl(input logic [31:0] val, input string tag);
        bus_set(0, 1, BASE + 32'h8, val, 4'h1);
        tick(tag);
        idle();
    endtask

    initial begin
        logic [7:0] nxt;
        bit         acc;
        int         r, off;
        logic [31:0] sd;
        idle();
        src_set(0, 8'h00);
        model_reset();
        #12;
        check("rst_data", bus.dm_data_l_o, 32'h0);
        check("rst_irq", 32'(bus.irq_o), 32'h0);
        rst = 1'b1;
        @(posedge wclk);
        #1;
        check("rst_ready", 32'(bus.in_ready_o), 32'h1);
        check("rst_ldone", 32'(bus.dm_load_done_o), 32'h0);

        // 1: push three bytes, read them back-to-back
        for (int i = 0; i < 3; i++) begin
            src_set(1, 8'h41 + 8'(i));
            tick("t1_push");
        end
        src_set(0, 8'h00);
        bus_set(1, 0, BASE, 32'h0, 4'h0);
        for (int i = 0; i < 3; i++) begin
            tick("t1_ld");
            check("t1_byte", bus.dm_data_l_o, 32'h8000_0041 + 32'(i));
        end
        idle();
        tick("t1_idle");
        check("t1_done_drop", 32'(bus.dm_load_done_o), 32'h0);
        load(BASE + 32'h4, "t1_stat");
        check("t1_count0", bus.dm_data_l_o, 32'h0);

        // 2: fill, overflow, pop one, clear overflow
        for (int i = 0; i < 16; i++) begin
            src_set(1, 8'(i));
            tick("t2_fill");
        end
        src_set(1, 8'h10);
        tick("t2_hold");
        check("t2_full_ready", 32'(bus.in_ready_o), 32'h0);
        load(BASE + 32'h4, "t2_stat");
        check("t2_status_ovf", bus.dm_data_l_o, 32'h8000_0010);
        load(BASE, "t2_pop");
        check("t2_pop_byte", bus.dm_data_l_o, 32'h8000_0000);
        tick("t2_take");
        src_set(0, 8'h00);
        store_ctrl(32'h4, "t2_ovfclr");
        tick("t2_wait");
        load(BASE + 32'h4, "t2_stat2");
        check("t2_status_clr", bus.dm_data_l_o, 32'h0000_0010);

        // 3: stream through a full FIFO with interleaved pops
        nxt = 8'h20;
        for (int i = 0; i < 40; i++) begin
            if (i % 2 == 0) bus_set(1, 0, BASE, 32'h0, 4'h0);
            else            idle();
            src_set(1, nxt);
            acc = bus.in_ready_o;
            tick("t3_stream");
            if (acc) nxt++;
        end
        src_set(0, 8'h00);
        idle();
        load(BASE + 32'h4, "t3_stat");
        check("t3_full_again", bus.dm_data_l_o, 32'h8000_0010);
        bus_set(1, 0, BASE, 32'h0, 4'h0);
        for (int i = 0; i < 16; i++) tick("t3_drain");
        check("t3_last_byte", bus.dm_data_l_o, {24'h800000, nxt - 8'h1});
        idle();

        // 4: read an empty FIFO
        store_ctrl(32'h4, "t4_clr");
        load(BASE, "t4_empty");
        check("t4_empty_data", bus.dm_data_l_o, 32'h0);
        check("t4_empty_done", 32'(bus.dm_load_done_o), 32'h1);
        load(BASE + 32'h4, "t4_stat");
        check("t4_status", bus.dm_data_l_o, 32'h0);

        // 5: interrupt enable, then flush racing a push
        store_ctrl(32'h2, "t5_ie");
        tick("t5_wait");
        src_set(1, 8'h55);
        tick("t5_push");
        src_set(0, 8'h00);
        tick("t5_irq");
        check("t5_irq_high", 32'(bus.irq_o), 32'h1);
        src_set(1, 8'h66);
        store_ctrl(32'h3, "t5_flush");
        src_set(0, 8'h00);
        tick("t5_f1");
        tick("t5_f2");
        check("t5_irq_low", 32'(bus.irq_o), 32'h0);
        load(BASE + 32'h4, "t5_stat");
        check("t5_status", bus.dm_data_l_o, 32'h0);
        store_ctrl(32'h0, "t5_ie_off");
        tick("t5_wait2");

        // 6: window edges, then reset during a load
        load(32'h1000_0000, "t6_out");
        check("t6_out_done", 32'(bus.dm_load_done_o), 32'h0);
        bus_set(0, 1, 32'h1000_0000, 32'h7, 4'hF);
        tick("t6_out_st");
        idle();
        tick("t6_out_st2");
        check("t6_out_sdone", 32'(bus.dm_store_done_o), 32'h0);
        load(32'h1000_001C, "t6_rsvd");
        check("t6_rsvd_data", bus.dm_data_l_o, 32'h0);
        check("t6_rsvd_done", 32'(bus.dm_load_done_o), 32'h1);
        src_set(1, 8'h77);
        tick("t6_push");
        src_set(0, 8'h00);
        bus_set(1, 1, BASE + 32'h4, 32'h2, 4'h1);
        #3;
        rst = 1'b0;
        #1;
        check("t6_rst_ldone", 32'(bus.dm_load_done_o), 32'h0);
        check("t6_rst_sdone", 32'(bus.dm_store_done_o), 32'h0);
        check("t6_rst_data", bus.dm_data_l_o, 32'h0);
        check("t6_rst_irq", 32'(bus.irq_o), 32'h0);
        idle();
        @(posedge wclk);
        #2;
        rst = 1'b1;
        model_reset();
        tick("t6_after");
        check("t6_after_done", 32'(bus.dm_load_done_o), 32'h0);

        // Randomized traffic against the reference model
        for (int i = 0; i < 800; i++) begin
            src_set(($urandom_range(0, 99) < ((i < 400) ? 75 : 35)), 8'($urandom));
            r = $urandom_range(0, 99);
            if (r < 25) begin
                off = $urandom_range(0, 4);
                if (off == 4) bus_set(1, 0, 32'h1000_0000 + 32'($urandom_range(0, 3) * 4), 0, 0);
                else          bus_set(1, 0, BASE + 32'(off * 4), 32'h0, 4'h0);
            end else if (r < 33) begin
                off = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : 2;
                sd  = 32'($urandom_range(0, 7) & 6);
                if ($urandom_range(0, 3) == 0) sd[0] = 1'b1;
                if (bus.in_valid_i) sd[2] = 1'b0;
                bus_set($urandom_range(0, 9) == 0, 1, BASE + 32'(off * 4), sd,
                        4'($urandom_range(0, 15)));
            end else begin
                idle();
            end
            tick("rand");
        end
        idle();
        src_set(0, 8'h00);
        tick("rand_end");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
